// File: rtl/cobdd_request_arbiter_pkg.sv
// Shared types for the coprocessor bridge request arbiter.
package cobdd_request_arbiter_pkg;

  // Default widths track the BDD codebase node-index and variable widths.
  localparam int COBDD_INDEX_W = 30;
  localparam int COBDD_VAR_W   = 16;

  typedef enum logic {
    REQ_APPLY = 1'b0,
    REQ_FOI   = 1'b1
  } req_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FIN   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cobdd_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly
// after the pointer position, wrapping around.
module cobdd_request_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/cobdd_request_arbiter.sv
// Shares one HPS coprocessor bridge between NUM_REQ BDD worker pipelines.
// One request is outstanding at a time; responses are registered and routed
// back to the owner with a one-cycle pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | pick a requester (round robin) or take a finish request
//   ST_ISSUE | present registered operands to the bridge until !co_busy
//   ST_WAIT  | count latency, wait for the matching done strobe
//   ST_RESP  | pulse rsp_valid to the owner
//   ST_FIN   | present co_finished until !co_busy, then pulse fin_ack
module cobdd_request_arbiter
  import cobdd_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int INDEX_W = COBDD_INDEX_W,
  parameter int VAR_W   = COBDD_VAR_W,
  parameter int LAT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_is_foi,
  input  logic [NUM_REQ-1:0]         req_fetch_f,
  input  logic [NUM_REQ-1:0]         req_fetch_g,
  input  logic [NUM_REQ*INDEX_W-1:0] req_a,
  input  logic [NUM_REQ*INDEX_W-1:0] req_b,
  input  logic [NUM_REQ*VAR_W-1:0]   req_top,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [INDEX_W-1:0]         rsp_fnv,
  output logic [INDEX_W-1:0]         rsp_fv,
  output logic [INDEX_W-1:0]         rsp_gnv,
  output logic [INDEX_W-1:0]         rsp_gv,
  output logic [INDEX_W-1:0]         rsp_result,
  input  logic                       fin_valid,
  input  logic [INDEX_W-1:0]         fin_result,
  output logic                       fin_ack,
  output logic [INDEX_W-1:0]         co_apply_f,
  output logic [INDEX_W-1:0]         co_apply_g,
  output logic [INDEX_W-1:0]         co_e,
  output logic [INDEX_W-1:0]         co_t,
  output logic                       co_fetch_f,
  output logic                       co_fetch_g,
  output logic [VAR_W-1:0]           co_top,
  output logic                       co_apply_valid,
  output logic                       co_foi_valid,
  output logic                       co_finished,
  output logic [INDEX_W-1:0]         co_final_result,
  input  logic                       co_busy,
  input  logic                       co_apply_done,
  input  logic [INDEX_W-1:0]         co_fnv,
  input  logic [INDEX_W-1:0]         co_fv,
  input  logic [INDEX_W-1:0]         co_gnv,
  input  logic [INDEX_W-1:0]         co_gv,
  input  logic                       co_foi_done,
  input  logic [INDEX_W-1:0]         co_foi_result,
  output logic                       proto_err,
  output logic [LAT_W-1:0]           last_latency
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  req_type_e           type_q, type_d;
  logic                fetch_f_q, fetch_f_d;
  logic                fetch_g_q, fetch_g_d;
  logic [INDEX_W-1:0]  a_q, a_d;
  logic [INDEX_W-1:0]  b_q, b_d;
  logic [VAR_W-1:0]    top_q, top_d;
  logic [INDEX_W-1:0]  fin_res_q, fin_res_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]    last_lat_q, last_lat_d;
  logic [INDEX_W-1:0]  rsp_fnv_q, rsp_fnv_d;
  logic [INDEX_W-1:0]  rsp_fv_q, rsp_fv_d;
  logic [INDEX_W-1:0]  rsp_gnv_q, rsp_gnv_d;
  logic [INDEX_W-1:0]  rsp_gv_q, rsp_gv_d;
  logic [INDEX_W-1:0]  rsp_result_q, rsp_result_d;
  logic                proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                any_req;

  cobdd_request_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    type_d         = type_q;
    fetch_f_d      = fetch_f_q;
    fetch_g_d      = fetch_g_q;
    a_d            = a_q;
    b_d            = b_q;
    top_d          = top_q;
    fin_res_d      = fin_res_q;
    lat_cnt_d      = lat_cnt_q;
    last_lat_d     = last_lat_q;
    rsp_fnv_d      = rsp_fnv_q;
    rsp_fv_d       = rsp_fv_q;
    rsp_gnv_d      = rsp_gnv_q;
    rsp_gv_d       = rsp_gv_q;
    rsp_result_d   = rsp_result_q;
    proto_err_d    = proto_err_q;
    req_ready      = '0;
    rsp_valid      = '0;
    fin_ack        = 1'b0;
    co_apply_valid = 1'b0;
    co_foi_valid   = 1'b0;
    co_finished    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = grant;
          owner_d   = grant_idx;
          ptr_d     = grant_idx;
          type_d    = req_is_foi[grant_idx] ? REQ_FOI : REQ_APPLY;
          fetch_f_d = req_fetch_f[grant_idx];
          fetch_g_d = req_fetch_g[grant_idx];
          a_d       = req_a[grant_idx*INDEX_W +: INDEX_W];
          b_d       = req_b[grant_idx*INDEX_W +: INDEX_W];
          top_d     = req_top[grant_idx*VAR_W +: VAR_W];
          state_d   = ST_ISSUE;
        end else if (fin_valid) begin
          fin_res_d = fin_result;
          state_d   = ST_FIN;
        end
      end
      ST_ISSUE: begin
        co_apply_valid = (type_q == REQ_APPLY);
        co_foi_valid   = (type_q == REQ_FOI);
        if (!co_busy) begin
          lat_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q != '1) begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
        if (type_q == REQ_APPLY) begin
          if (co_foi_done) begin
            proto_err_d = 1'b1;
          end
          if (co_apply_done) begin
            rsp_fnv_d  = co_fnv;
            rsp_fv_d   = co_fv;
            rsp_gnv_d  = co_gnv;
            rsp_gv_d   = co_gv;
            last_lat_d = lat_cnt_q;
            state_d    = ST_RESP;
          end
        end else begin
          if (co_apply_done) begin
            proto_err_d = 1'b1;
          end
          if (co_foi_done) begin
            rsp_result_d = co_foi_result;
            last_lat_d   = lat_cnt_q;
            state_d      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = ST_IDLE;
      end
      ST_FIN: begin
        co_finished = 1'b1;
        if (!co_busy) begin
          fin_ack = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A done strobe with nothing outstanding is a bridge protocol violation.
    if ((state_q != ST_WAIT) && (co_apply_done || co_foi_done)) begin
      proto_err_d = 1'b1;
    end

    // Keep the handshake strobes quiet while reset is being applied.
    if (!reset) begin
      req_ready      = '0;
      rsp_valid      = '0;
      fin_ack        = 1'b0;
      co_apply_valid = 1'b0;
      co_foi_valid   = 1'b0;
      co_finished    = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      owner_q      <= '0;
      type_q       <= REQ_APPLY;
      fetch_f_q    <= 1'b0;
      fetch_g_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      top_q        <= '0;
      fin_res_q    <= '0;
      lat_cnt_q    <= '0;
      last_lat_q   <= '0;
      rsp_fnv_q    <= '0;
      rsp_fv_q     <= '0;
      rsp_gnv_q    <= '0;
      rsp_gv_q     <= '0;
      rsp_result_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      type_q       <= type_d;
      fetch_f_q    <= fetch_f_d;
      fetch_g_q    <= fetch_g_d;
      a_q          <= a_d;
      b_q          <= b_d;
      top_q        <= top_d;
      fin_res_q    <= fin_res_d;
      lat_cnt_q    <= lat_cnt_d;
      last_lat_q   <= last_lat_d;
      rsp_fnv_q    <= rsp_fnv_d;
      rsp_fv_q     <= rsp_fv_d;
      rsp_gnv_q    <= rsp_gnv_d;
      rsp_gv_q     <= rsp_gv_d;
      rsp_result_q <= rsp_result_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // The bridge sees the same operand registers under both naming schemes;
  // only the fields belonging to the asserted valid are meaningful.
  assign co_apply_f      = a_q;
  assign co_apply_g      = b_q;
  assign co_e            = a_q;
  assign co_t            = b_q;
  assign co_fetch_f      = fetch_f_q;
  assign co_fetch_g      = fetch_g_q;
  assign co_top          = top_q;
  assign co_final_result = fin_res_q;
  assign rsp_fnv         = rsp_fnv_q;
  assign rsp_fv          = rsp_fv_q;
  assign rsp_gnv         = rsp_gnv_q;
  assign rsp_gv          = rsp_gv_q;
  assign rsp_result      = rsp_result_q;
  assign proto_err       = proto_err_q;
  assign last_latency    = last_lat_q;

endmodule
